mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL be the number of consecutive LSU grants allowed while fetch waits.
REQ-002 i_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-low reset.
REQ-004 i_if_req  in  1  fetch request, held until granted; i_if_addr  in  32  fetch address.
REQ-005 o_if_gnt  out  1  fetch request accepted; o_if_rvalid  out  1  fetch data valid; o_if_rdata  out  32  fetch data.
REQ-006 i_ls_req  in  1  LSU request, held until granted; i_ls_we  in  1  store when 1; i_ls_addr  in  32  address; i_ls_wdata  in  32  store data; i_ls_size  in  2  byte/half/word.
REQ-007 o_ls_gnt  out  1  LSU request accepted; o_ls_rvalid  out  1  load data valid; o_ls_rdata  out  32  load data.
REQ-008 o_mem_req, o_mem_we  out  1 each; o_mem_addr, o_mem_wdata  out  32 each; o_mem_size  out  2  shared memory port command.
REQ-009 i_mem_ready  in  1  memory accepts command; i_mem_rvalid  in  1  read data valid; i_mem_rdata  in  32  read data.
REQ-010 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-012 IDLE: any request -> winner's gnt asserted combinationally for exactly that cycle; owner, we, addr, wdata, size latched; next state REQ.
REQ-013 Arbitration: LSU wins when both request, unless starve count == STARVE_LIMIT, then fetch wins.
REQ-014 Starve counter SHALL increment on LSU grant while i_if_req=1, clear on fetch grant, hold otherwise; it SHALL never exceed STARVE_LIMIT.
REQ-015 Fetch transactions SHALL always be reads (o_mem_we=0, o_mem_size=2'b10).
REQ-016 REQ: o_mem_req=1 with latched command stable until i_mem_ready=1; then reads -> WAIT, writes -> IDLE (write complete, no rvalid).
REQ-017 WAIT: o_mem_req=0; on i_mem_rvalid=1, owner's rvalid=1 and rdata=i_mem_rdata that cycle (combinational pass-through), next state IDLE.
REQ-018 Non-owner rvalid SHALL stay 0; rdata outputs SHALL be 0 when the respective rvalid=0.
REQ-019 i_mem_rvalid in IDLE or REQ SHALL be ignored (no rvalid output, no state change).
REQ-020 No grant SHALL be issued outside IDLE; requests arriving during REQ/WAIT wait.
REQ-021 Minimum read latency: grant at cycle t, o_mem_req at t+1, ready at t+1, rvalid earliest t+2, next grant earliest t+3.
REQ-022 No requests in IDLE -> stay IDLE, all outputs 0.

Reset
REQ-023 i_reset=0 at a clock edge SHALL force IDLE, clear starve counter, owner and latched command, regardless of state.
REQ-024 During and after reset, o_mem_req, o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_busy, o_mem_we SHALL be 0 and all data/address outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it; a late i_mem_rvalid SHALL be dropped per REQ-019.

Verification
REQ-026 Fetch only: i_if_addr=0x100, ready=1, rvalid two cycles after grant with 0xDEADBEEF -> o_if_gnt 1 cycle, o_mem_addr=0x100 we=0, o_if_rvalid=1 with 0xDEADBEEF, back to IDLE.
REQ-027 Simultaneous: if_req and ls_req (load 0x200) in same IDLE cycle -> o_ls_gnt first; fetch granted in next IDLE cycle.
REQ-028 Starvation: i_if_req held, LSU requesting continuously, STARVE_LIMIT=4 -> exactly 4 LSU grants, then o_if_gnt, counter back to 0.
REQ-029 Store with backpressure: i_ls_we=1, addr 0x300, wdata 0x12345678, size 2'b00, i_mem_ready low 3 cycles -> command stable all 4 cycles of REQ, no o_ls_rvalid, IDLE after ready.
REQ-030 Reset in WAIT: i_reset=0 one cycle, then i_mem_rvalid=1 -> no rvalid outputs, o_busy=0, new request granted normally.
REQ-031 Spurious i_mem_rvalid=1 in IDLE -> o_if_rvalid=o_ls_rvalid=0, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and LSU share one memory port,
// one transaction outstanding, LSU priority with bounded fetch starvation.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [1:0]  i_ls_size,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_size,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;
  logic             cmd_we;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic [1:0]       cmd_size;
  logic [CNT_W-1:0] starve_cnt;
  logic             ls_wins;

  // LSU has priority unless fetch has already been passed over STARVE_LIMIT times
  assign ls_wins = i_ls_req && !(i_if_req && (starve_cnt == CNT_MAX));

  // State register, command latch and starvation counter
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      cmd_we     <= 1'b0;
      cmd_addr   <= 32'h0;
      cmd_wdata  <= 32'h0;
      cmd_size   <= 2'b00;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (o_ls_gnt) begin
        owner     <= OWN_LS;
        cmd_we    <= i_ls_we;
        cmd_addr  <= i_ls_addr;
        cmd_wdata <= i_ls_wdata;
        cmd_size  <= i_ls_size;
        if (i_if_req && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (o_if_gnt) begin
        owner      <= OWN_IF;
        cmd_we     <= 1'b0;
        cmd_addr   <= i_if_addr;
        cmd_wdata  <= 32'h0;
        cmd_size   <= SIZE_WORD;
        starve_cnt <= '0;
      end
    end
  end

  // Next-state and outputs; everything is held at zero while reset is asserted
  always_comb begin
    next_state  = state;
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = 32'h0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = 32'h0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_size  = 2'b00;
    o_busy      = 1'b0;
    if (i_reset) begin
      o_busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (ls_wins) begin
            o_ls_gnt   = 1'b1;
            next_state = REQ;
          end else if (i_if_req) begin
            o_if_gnt   = 1'b1;
            next_state = REQ;
          end
        end
        REQ: begin
          o_mem_req   = 1'b1;
          o_mem_we    = cmd_we;
          o_mem_addr  = cmd_addr;
          o_mem_wdata = cmd_wdata;
          o_mem_size  = cmd_size;
          if (i_mem_ready) next_state = cmd_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            if (owner == OWN_LS) begin
              o_ls_rvalid = 1'b1;
              o_ls_rdata  = i_mem_rdata;
            end else begin
              o_if_rvalid = 1'b1;
              o_if_rdata  = i_mem_rdata;
            end
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule
